// File: rtl/fmul_arbiter_if.sv
// rtl/fmul_arbiter_if.sv - request, response and fmul-side buses of the shared fmul arbiter
interface fmul_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [32*NREQ-1:0] rsp_data;
    logic [31:0]        fmul_a;
    logic [31:0]        fmul_b;
    logic               fmul_valid;
    logic [31:0]        fmul_result;
    logic               fmul_out_valid;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, fmul_result, fmul_out_valid,
        output req_ready, rsp_valid, rsp_data, fmul_a, fmul_b, fmul_valid
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, fmul_result, fmul_out_valid,
        input  req_ready, rsp_valid, rsp_data, fmul_a, fmul_b, fmul_valid
    );
endinterface

// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin sharing of one pipelined fmul with credit-checked response FIFOs
// Optional macro FMUL_ARB_PERF_EN adds the perf_stall / perf_issued counters.
module fmul_arbiter #(
    parameter int NREQ       = 4,
    parameter int LAT        = 3,
    parameter int RESP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fmul_arbiter_if.slave bus,
    output logic          busy,
`ifdef FMUL_ARB_PERF_EN
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_issued,
`endif
    output logic          err
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [IW-1:0]  rr_q, rr_d;
    logic           iss_valid_q, iss_valid_d;
    logic [IW-1:0]  iss_tag_q, iss_tag_d;
    logic [31:0]    iss_a_q, iss_a_d, iss_b_q, iss_b_d;
    logic [LAT-1:0] pipe_valid_q, pipe_valid_d;
    logic [IW-1:0]  pipe_tag_q [LAT];
    logic [IW-1:0]  pipe_tag_d [LAT];
    logic           cap_valid_q, cap_valid_d, cap_push_q, cap_push_d;
    logic [IW-1:0]  cap_tag_q, cap_tag_d;
    logic [31:0]    cap_data_q, cap_data_d;
    logic [CW-1:0]  inflight_q [NREQ];
    logic [CW-1:0]  inflight_d [NREQ];
    logic [CW-1:0]  count_q [NREQ];
    logic [CW-1:0]  count_d [NREQ];
    logic [PW-1:0]  wptr_q [NREQ];
    logic [PW-1:0]  wptr_d [NREQ];
    logic [PW-1:0]  rptr_q [NREQ];
    logic [PW-1:0]  rptr_d [NREQ];
    logic [31:0]    mem_q [NREQ][RESP_DEPTH];
    logic [31:0]    mem_d [NREQ][RESP_DEPTH];
    logic           err_q, err_d;

    logic [NREQ-1:0] eligible, grant, push, pop;
    logic            grant_any;
    logic [IW-1:0]   grant_idx;

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A requester may only issue while every result it has outstanding already owns a FIFO slot.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = bus.req_valid[i] &&
                (({1'b0, inflight_q[i]} + {1'b0, count_q[i]}) < (CW+1)'(RESP_DEPTH));
        end
    end

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && eligible[rr_index(rr_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_index(rr_q, k);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        rr_d        = rr_q;
        iss_valid_d = grant_any;
        iss_tag_d   = iss_tag_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        if (grant_any) begin
            rr_d      = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            iss_tag_d = grant_idx;
            iss_a_d   = bus.req_a[32*grant_idx +: 32];
            iss_b_d   = bus.req_b[32*grant_idx +: 32];
        end

        pipe_valid_d    = '0;
        pipe_tag_d      = pipe_tag_q;
        pipe_valid_d[0] = iss_valid_q;
        pipe_tag_d[0]   = iss_tag_q;
        for (int s = 1; s < LAT; s++) begin
            pipe_valid_d[s] = pipe_valid_q[s-1];
            pipe_tag_d[s]   = pipe_tag_q[s-1];
        end

        // Results are registered once before the FIFO write; that slot still counts as in flight.
        cap_valid_d = pipe_valid_q[LAT-1];
        cap_push_d  = pipe_valid_q[LAT-1] & bus.fmul_out_valid;
        cap_tag_d   = pipe_tag_q[LAT-1];
        cap_data_d  = bus.fmul_result;
        err_d       = err_q | (pipe_valid_q[LAT-1] ^ bus.fmul_out_valid);
    end

    always_comb begin
        push       = '0;
        pop        = '0;
        inflight_d = inflight_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_d      = mem_q;
        for (int i = 0; i < NREQ; i++) begin
            push[i]       = cap_push_q && (cap_tag_q == IW'(i));
            pop[i]        = bus.rsp_ready[i] && (count_q[i] != '0);
            inflight_d[i] = inflight_q[i] + CW'(grant[i])
                            - CW'(cap_valid_q && (cap_tag_q == IW'(i)));
            count_d[i]    = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = cap_data_q;
                wptr_d[i]           = ptr_inc(wptr_q[i]);
            end
            if (pop[i]) rptr_d[i] = ptr_inc(rptr_q[i]);
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        busy          = iss_valid_q;
        for (int i = 0; i < NREQ; i++) begin
            bus.rsp_valid[i]          = (count_q[i] != '0);
            bus.rsp_data[32*i +: 32]  = mem_q[i][rptr_q[i]];
            busy                      = busy | (inflight_q[i] != '0) | (count_q[i] != '0);
        end
    end

    assign bus.req_ready  = grant;
    assign bus.fmul_a     = iss_a_q;
    assign bus.fmul_b     = iss_b_q;
    assign bus.fmul_valid = iss_valid_q;
    assign err            = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= '0;
            iss_valid_q  <= 1'b0;
            iss_tag_q    <= '0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            pipe_valid_q <= '0;
            cap_valid_q  <= 1'b0;
            cap_push_q   <= 1'b0;
            cap_tag_q    <= '0;
            cap_data_q   <= '0;
            err_q        <= 1'b0;
            for (int s = 0; s < LAT; s++) pipe_tag_q[s] <= '0;
            for (int i = 0; i < NREQ; i++) begin
                inflight_q[i] <= '0;
                count_q[i]    <= '0;
                wptr_q[i]     <= '0;
                rptr_q[i]     <= '0;
                for (int j = 0; j < RESP_DEPTH; j++) mem_q[i][j] <= '0;
            end
        end else begin
            rr_q         <= rr_d;
            iss_valid_q  <= iss_valid_d;
            iss_tag_q    <= iss_tag_d;
            iss_a_q      <= iss_a_d;
            iss_b_q      <= iss_b_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
            cap_valid_q  <= cap_valid_d;
            cap_push_q   <= cap_push_d;
            cap_tag_q    <= cap_tag_d;
            cap_data_q   <= cap_data_d;
            err_q        <= err_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            mem_q        <= mem_d;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_chk
        a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
            !(push[gi] && (count_q[gi] == CW'(RESP_DEPTH))));
    end

`ifdef FMUL_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_issued_q, perf_issued_d;

    // With a request pending, the only reason for no grant is exhausted credits.
    always_comb begin
        perf_stall_d = perf_stall_q;
        if ((|bus.req_valid) && !grant_any && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
        perf_issued_d = perf_issued_q + {31'b0, grant_any};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_issued_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_issued_q <= perf_issued_d;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_issued = perf_issued_q;
`endif
endmodule

// File: tb/tb_fmul_arbiter.sv
// tb/tb_fmul_arbiter.sv - directed bench for fmul_arbiter with a transaction-level reference model
module tb_fmul_arbiter;
    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy, err;
    logic inj;
    int   tests = 0;
    int   fails = 0;

    fmul_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef FMUL_ARB_PERF_EN
    logic [31:0] perf_stall, perf_issued;
    fmul_arbiter #(.NREQ(NREQ), .LAT(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy),
        .perf_stall(perf_stall), .perf_issued(perf_issued), .err(err));
`else
    fmul_arbiter #(.NREQ(NREQ), .LAT(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .err(err));
`endif

    always #5 clk = ~clk;

    // Exact for normal operands whose product needs no rounding.
    function automatic logic [31:0] fmul_f(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        logic [63:0] d;
        if (a[30:0] == 31'b0 || b[30:0] == 31'b0) return {a[31] ^ b[31], 31'b0};
        ra = $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0});
        rb = $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'b0});
        d  = $realtobits(ra * rb);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    logic        fm_v [LAT];
    logic [31:0] fm_d [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                fm_v[s] <= 1'b0;
                fm_d[s] <= '0;
            end
        end else begin
            fm_v[0] <= bus.fmul_valid;
            fm_d[0] <= fmul_f(bus.fmul_a, bus.fmul_b);
            for (int s = 1; s < LAT; s++) begin
                fm_v[s] <= fm_v[s-1];
                fm_d[s] <= fm_d[s-1];
            end
        end
    end
    assign bus.fmul_out_valid = fm_v[LAT-1] | inj;
    assign bus.fmul_result    = fm_d[LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] mfifo [NREQ][$];
    int          outst [NREQ];
    int          rr_m = 0;
    int          cyc = 0;
    bit          err_m = 0;
    bit          fv_m = 0;
    logic [31:0] fa_m, fb_m;

    function automatic int exp_grant();
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (rr_m + k) % NREQ;
            if (bus.req_valid[idx] && (outst[idx] + mfifo[idx].size()) < DEPTH) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        cyc++;
        if (rst) begin
            pend.delete();
            for (int i = 0; i < NREQ; i++) begin
                mfifo[i].delete();
                outst[i] = 0;
            end
            rr_m = 0; err_m = 0; fv_m = 0;
        end else begin
            g = exp_grant();
            for (int i = 0; i < NREQ; i++)
                if (bus.rsp_ready[i] && mfifo[i].size() > 0) void'(mfifo[i].pop_front());
            while (pend.size() > 0 && pend[0].due == cyc) begin
                mfifo[pend[0].id].push_back(pend[0].data);
                outst[pend[0].id]--;
                void'(pend.pop_front());
            end
            fv_m = (g >= 0);
            if (g >= 0) begin
                fa_m = bus.req_a[32*g +: 32];
                fb_m = bus.req_b[32*g +: 32];
                pend.push_back('{due: cyc + LAT + 2, id: g, data: fmul_f(fa_m, fb_m)});
                outst[g]++;
                rr_m = (g + 1) % NREQ;
            end
            if (inj) err_m = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        int g;
        bit busy_m;
        g = exp_grant();
        chk("req_ready", 32'(bus.req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        busy_m = 0;
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("rsp_valid[%0d]", i), 32'(bus.rsp_valid[i]), 32'(mfifo[i].size() > 0));
            if (mfifo[i].size() > 0)
                chk($sformatf("rsp_data[%0d]", i), bus.rsp_data[32*i +: 32], mfifo[i][0]);
            if (outst[i] > 0 || mfifo[i].size() > 0) busy_m = 1;
        end
        chk("fmul_valid", 32'(bus.fmul_valid), 32'(fv_m));
        if (fv_m) begin
            chk("fmul_a", bus.fmul_a, fa_m);
            chk("fmul_b", bus.fmul_b, fb_m);
        end
        chk("busy", 32'(busy), 32'(busy_m));
        chk("err", 32'(err), 32'(err_m));
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic set_ops(input int k);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = 32'h3F80_0000 | (32'(i) << 20) | (32'(k & 15) << 16);
            bus.req_b[32*i +: 32] = 32'h4000_0000 | (32'(k & 7) << 20) | (32'(i) << 16);
        end
    endtask

    initial begin
        int ng;
        rst = 1'b1; inj = 1'b0;
        bus.req_valid = '0; bus.rsp_ready = '0; bus.req_a = '0; bus.req_b = '0;
        step(); step();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fmul_valid", 32'(bus.fmul_valid), 32'd0);
        chk("rst_fmul_a", bus.fmul_a, 32'd0);
        chk("rst_rsp_data", 32'(|bus.rsp_data), 32'd0);
        rst = 1'b0;
        step();

        // single op: 1.5 * 2.0
        bus.req_a[31:0] = 32'h3FC0_0000; bus.req_b[31:0] = 32'h4000_0000;
        bus.req_valid = 4'b0001;
        #1 chk("single_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        for (int k = 1; k < 5; k++) step();
        chk("single_rsp_not_yet", 32'(bus.rsp_valid[0]), 32'd0);
        step();
        chk("single_rsp_valid", 32'(bus.rsp_valid[0]), 32'd1);
        chk("single_rsp_data", bus.rsp_data[31:0], 32'h4040_0000);
        bus.rsp_ready = 4'b0001;
        step();
        chk("single_busy_after_pop", 32'(busy), 32'd0);

        // fairness: pointer sits at 1 after the single op
        bus.rsp_ready = 4'hF;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 16; k++) begin
            set_ops(k);
            #1 chk("fair_grant", 32'(bus.req_ready), 32'(1 << ((1 + k) % 4)));
            step();
            chk("fair_fmul_valid", 32'(bus.fmul_valid), 32'd1);
        end
        bus.req_valid = '0;
        for (int k = 0; k < 10; k++) step();

        // credit stall on requester 1
        ng = 0;
        bus.rsp_ready = 4'b1101;
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            set_ops(k + 3);
            #1 if (bus.req_ready[1]) ng++;
            step();
        end
        chk("stall_grants", 32'(ng), 32'd2);
        bus.rsp_ready = 4'hF;
        #1 if (bus.req_ready[1]) ng++;
        step();
        bus.rsp_ready = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            #1 if (bus.req_ready[1]) ng++;
            step();
        end
        chk("stall_release_grants", 32'(ng), 32'd3);
        chk("stall_ready_low", 32'(bus.req_ready[1]), 32'd0);
        bus.req_valid = '0; bus.rsp_ready = 4'hF;
        for (int k = 0; k < 10; k++) step();

        // mixed: requester 2 credit-blocked while 3 keeps asking
        bus.rsp_ready = 4'b1011;
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) step();
        bus.req_valid = 4'b1100;
        for (int k = 0; k < 10; k++) begin set_ops(k); step(); end
        ng = 0;
        bus.rsp_ready = 4'hF;
        #1 if (bus.req_ready[2]) ng++;
        step();
        bus.rsp_ready = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            set_ops(k + 5);
            #1 if (bus.req_ready[2]) ng++;
            step();
        end
        chk("mixed_req2_grants", 32'(ng), 32'd1);
        bus.req_valid = '0; bus.rsp_ready = 4'hF;
        for (int k = 0; k < 12; k++) step();

        // reset with three ops in flight
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) step();
        bus.req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_err", 32'(err), 32'd0);
        for (int k = 0; k < 10; k++) step();
        chk("rstmid_no_stale", 32'(bus.rsp_valid), 32'd0);

        // spurious fmul out_valid with nothing in flight
        inj = 1'b1;
        step();
        inj = 1'b0;
        chk("inj_err_set", 32'(err), 32'd1);
        for (int k = 0; k < 5; k++) step();
        chk("inj_err_sticky", 32'(err), 32'd1);
        chk("inj_fifo_untouched", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("inj_err_cleared", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
